cache_arbiter: RTL and testbench
================================

# cache_arbiter

Two-port arbiter in front of the 2-way L1 cache's CPU-side (C1) command bus. Accepts read/write/invalidate requests from two requesters, grants one at a time with round-robin fairness, and sequences the granted request onto the cache's 16-bit C1 bus. Sequencing includes the second data beat for 32-bit writes. It then waits for the cache's C1 response and returns the result to the owning requester. It sits between the CPU-side masters and the cache; the cache itself is unchanged.

## Interface
- ADDR_W, 19, byte address width: tag 10 + set 5 + offset 4
- DATA_W, 16, C1 data bus width
- TIMEOUT, 255, response watchdog limit in cycles; used only with the macro
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  2  per-requester request; held high until that requester's resp_valid
- req_cmd  in  2x3  per-requester C1 command (NOP 0, READ8 1, READ16 2, READ32 3, INV_LINE 4, WRITE8 5, WRITE16 6, WRITE32 7)
- req_addr  in  2xADDR_W  per-requester byte address
- req_wdata  in  2x32  per-requester write data, low-aligned
- gnt  out  2  one-hot; high for the whole transaction of the granted requester
- resp_valid  out  2  one-cycle response pulse to the owning requester
- resp_rdata  out  32  read data, zero-extended; 0 for writes and INV_LINE
- resp_err  out  1  timeout indication, valid with resp_valid
- c1_cmd_o  out  3  command to cache
- c1_addr_o  out  ADDR_W  address to cache
- c1_data_o  out  DATA_W  write data to cache
- c1_cmd_i  in  3  cache response command (NOP 0, RESPONSE 7)
- c1_data_i  in  DATA_W  cache read data

## Operation
- States: IDLE, SEND, SEND_HI, WAIT, RECV_HI, RESP.
- **IDLE**
  - A request is pending when req_valid[i]=1 and req_cmd[i]!=NOP. Requests whose command is NOP are ignored.
  - One pending request: grant it.
  - Two pending requests: grant the requester not granted last. The round-robin pointer resets to favour requester 0.
  - On grant: latch cmd, addr and wdata; set gnt; go to SEND.
- **SEND**
  - Drive c1_cmd_o=cmd, c1_addr_o=addr, c1_data_o=wdata[15:0].
  - WRITE32 goes to SEND_HI; all other commands go to WAIT.
- **SEND_HI**
  - Drive c1_cmd_o=NOP, c1_data_o=wdata[31:16], c1_addr_o=addr.
  - Go to WAIT.
- **WAIT**
  - All c1 outputs are 0.
  - When c1_cmd_i=RESPONSE: capture c1_data_i into rdata[15:0].
    - READ32 goes to RECV_HI.
    - Any other command goes to RESP.
  - Read data width: READ8 keeps bits [7:0]; READ16 keeps [15:0]. Writes and INV_LINE return rdata=0.
- **RECV_HI**
  - Capture c1_data_i into rdata[31:16] unconditionally; the cache delivers the high beat in the cycle right after the low beat.
  - Go to RESP.
- **RESP**
  - Pulse resp_valid[owner] with resp_rdata and resp_err.
  - Clear gnt, update the round-robin pointer, go to IDLE.
- c1_cmd_i=RESPONSE outside WAIT/RECV_HI is ignored.
- Requester protocol: keep req inputs stable while gnt is high, and deassert req_valid before the edge following resp_valid.
- Reset: all outputs are 0, state IDLE, pointer favours requester 0. A reset mid-transaction aborts it with no response; the cache response arriving after reset is ignored.

## Timing
- Request sampled at edge N means gnt and SEND are active during cycle N+1.
- SEND_HI, when present, is cycle N+2.
- A response seen at edge M means RESP (resp_valid) is active in cycle M+1, or M+2 for READ32.
- Earliest next grant is sampled at the edge ending the RESP cycle.
- Minimum turnaround for non-32-bit commands, with the cache responding in the first WAIT cycle: 4 cycles from request to resp_valid.

## Configuration
- CACHE_ARBITER_TIMEOUT_EN defined:
  - An 8-bit watchdog counts WAIT cycles, cleared on entry to WAIT.
  - When the count reaches TIMEOUT with no response, go to RESP with resp_err=1 and resp_rdata=0.
  - A response arriving later is ignored.
- Not defined: no counter; WAIT lasts until the cache responds; resp_err is tied to 0.

## Structure
- Shared package cache_pkg: C1 command constants, C1_RESPONSE, C2 command constants, the arbiter state enum, ADDR_W/DATA_W defaults.
- One sub-module: rr_arb2. It is the combinational two-way round-robin pick from the pending vector and pointer; the pointer register lives in the parent.

## Test plan
- Single READ8 on port 0, addr 0x1234; cache responds with data 0x00AB two cycles after SEND -> c1_cmd_o=1 with 0x1234 for one cycle; resp_valid[0] with rdata 0x000000AB; resp_err=0.
- WRITE32 on port 1, wdata 0xDEADBEEF -> SEND drives cmd 7 and data 0xBEEF; the next cycle drives NOP and data 0xDEAD; the write response gives resp_valid[1] with rdata 0.
- READ32 whose cache beats are 0x5678 then 0x1234 -> rdata 0x12345678.
- Both ports request continuously after reset -> grants go 0,1,0,1; no back-to-back grant to the same port.
- Port 0 holds req_valid with cmd NOP while port 1 requests INV_LINE -> port 1 is granted; port 0 is never granted.
- With the macro and TIMEOUT=4, the cache never responds -> resp_err=1 after 4 WAIT cycles; a later RESPONSE is ignored. Also assert rst_n low mid-WAIT -> all outputs 0 next cycle and no resp_valid.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: shared C1/C2 command encodings, arbiter state enum and bus width defaults
package cache_pkg;

    localparam int ADDR_W_DEF = 19;
    localparam int DATA_W_DEF = 16;

    localparam logic [2:0] C1_NOP      = 3'd0;
    localparam logic [2:0] C1_READ8    = 3'd1;
    localparam logic [2:0] C1_READ16   = 3'd2;
    localparam logic [2:0] C1_READ32   = 3'd3;
    localparam logic [2:0] C1_INV_LINE = 3'd4;
    localparam logic [2:0] C1_WRITE8   = 3'd5;
    localparam logic [2:0] C1_WRITE16  = 3'd6;
    localparam logic [2:0] C1_WRITE32  = 3'd7;
    localparam logic [2:0] C1_RESPONSE = 3'd7;

    localparam logic [1:0] C2_NOP        = 2'd0;
    localparam logic [1:0] C2_READ_LINE  = 2'd1;
    localparam logic [1:0] C2_WRITE_LINE = 2'd2;
    localparam logic [1:0] C2_RESPONSE   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_SEND_HI,
        ST_WAIT,
        ST_RECV_HI,
        ST_RESP
    } arb_state_e;

    // Low response beat trimmed to the width the command asked for; non-reads return nothing
    function automatic logic [15:0] low_beat(input logic [2:0] cmd, input logic [15:0] data);
        return cmd == C1_READ8 ? {8'h00, data[7:0]} :
               (cmd == C1_READ16 || cmd == C1_READ32) ? data : 16'h0000;
    endfunction

endpackage

// File: rtl/cache_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick; ptr_i names the requester that wins a tie
module rr_arb2 (
    input  logic [1:0] pend_i,
    input  logic       ptr_i,
    output logic       any_o,
    output logic       pick_o
);

    assign any_o  = |pend_i;
    assign pick_o = &pend_i ? ptr_i : pend_i[1];

endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: two-port round-robin arbiter sequencing requests onto the cache C1 bus (watchdog under CACHE_ARBITER_TIMEOUT_EN)
module cache_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    input  logic [5:0]            req_cmd,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [63:0]           req_wdata,
    output logic [1:0]            gnt,
    output logic [1:0]            resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [2:0]            c1_cmd_o,
    output logic [ADDR_W-1:0]     c1_addr_o,
    output logic [DATA_W-1:0]     c1_data_o,
    input  logic [2:0]            c1_cmd_i,
    input  logic [DATA_W-1:0]     c1_data_i
);

    arb_state_e        state_q;
    logic              ptr_q;
    logic              owner_q;
    logic [2:0]        cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [15:0]       rlo_q;
    logic [1:0]        gnt_q;
    logic [1:0]        resp_valid_q;
    logic [31:0]       resp_rdata_q;
    logic [2:0]        c1_cmd_q;
    logic [ADDR_W-1:0] c1_addr_q;
    logic [DATA_W-1:0] c1_data_q;
    logic [1:0]        pend;
    logic              any;
    logic              pick;
    logic [2:0]        sel_cmd;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic              rsp;
    logic              timeout;

    assign pend[0]   = req_valid[0] && req_cmd[2:0] != C1_NOP;
    assign pend[1]   = req_valid[1] && req_cmd[5:3] != C1_NOP;
    assign sel_cmd   = pick ? req_cmd[5:3] : req_cmd[2:0];
    assign sel_addr  = pick ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    assign sel_wdata = pick ? req_wdata[63:32] : req_wdata[31:0];
    assign rsp       = c1_cmd_i == C1_RESPONSE;

    rr_arb2 u_rr (
        .pend_i (pend),
        .ptr_i  (ptr_q),
        .any_o  (any),
        .pick_o (pick)
    );

`ifdef CACHE_ARBITER_TIMEOUT_EN
    logic [7:0] wdog_q;
    logic       err_q;

    assign timeout  = wdog_q == 8'(TIMEOUT - 1);
    assign resp_err = err_q;

    // Watchdog counts consecutive WAIT cycles and sits at zero elsewhere, so every WAIT starts fresh
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= state_q == ST_WAIT ? wdog_q + 8'd1 : '0;
            err_q  <= state_q == ST_WAIT && !rsp && timeout;
        end
    end
`else
    logic [7:0] timeout_unused;

    assign timeout_unused = 8'(TIMEOUT);
    assign timeout        = 1'b0;
    assign resp_err       = 1'b0;
`endif

    // Transaction FSM; every output is registered and loaded on the edge entering the state that shows it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= 1'b0;
            owner_q      <= 1'b0;
            cmd_q        <= C1_NOP;
            addr_q       <= '0;
            wdata_q      <= '0;
            rlo_q        <= '0;
            gnt_q        <= '0;
            resp_valid_q <= '0;
            resp_rdata_q <= '0;
            c1_cmd_q     <= C1_NOP;
            c1_addr_q    <= '0;
            c1_data_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (any) begin
                    state_q   <= ST_SEND;
                    owner_q   <= pick;
                    cmd_q     <= sel_cmd;
                    addr_q    <= sel_addr;
                    wdata_q   <= sel_wdata;
                    gnt_q     <= pick ? 2'b10 : 2'b01;
                    c1_cmd_q  <= sel_cmd;
                    c1_addr_q <= sel_addr;
                    c1_data_q <= sel_wdata[15:0];
                end
                ST_SEND: begin
                    state_q   <= cmd_q == C1_WRITE32 ? ST_SEND_HI : ST_WAIT;
                    c1_cmd_q  <= C1_NOP;
                    c1_addr_q <= cmd_q == C1_WRITE32 ? addr_q : '0;
                    c1_data_q <= cmd_q == C1_WRITE32 ? wdata_q[31:16] : '0;
                end
                ST_SEND_HI: begin
                    state_q   <= ST_WAIT;
                    c1_addr_q <= '0;
                    c1_data_q <= '0;
                end
                ST_WAIT: if (rsp) begin
                    rlo_q        <= low_beat(cmd_q, c1_data_i);
                    state_q      <= cmd_q == C1_READ32 ? ST_RECV_HI : ST_RESP;
                    resp_valid_q <= cmd_q == C1_READ32 ? 2'b00 : gnt_q;
                    resp_rdata_q <= {16'h0000, low_beat(cmd_q, c1_data_i)};
                end else if (timeout) begin
                    state_q      <= ST_RESP;
                    resp_valid_q <= gnt_q;
                    resp_rdata_q <= '0;
                end
                ST_RECV_HI: begin
                    state_q      <= ST_RESP;
                    resp_valid_q <= gnt_q;
                    resp_rdata_q <= {c1_data_i, rlo_q};
                end
                ST_RESP: begin
                    state_q      <= ST_IDLE;
                    resp_valid_q <= '0;
                    resp_rdata_q <= '0;
                    gnt_q        <= '0;
                    ptr_q        <= ~owner_q;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign gnt        = gnt_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign c1_cmd_o   = c1_cmd_q;
    assign c1_addr_o  = c1_addr_q;
    assign c1_data_o  = c1_data_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed-vector bench for cache_arbiter (timeout scenario only with CACHE_ARBITER_TIMEOUT_EN)
module tb_cache_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [5:0]  req_cmd;
    logic [37:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  gnt;
    logic [1:0]  resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [2:0]  c1_cmd_o;
    logic [18:0] c1_addr_o;
    logic [15:0] c1_data_o;
    logic [2:0]  c1_cmd_i;
    logic [15:0] c1_data_i;

    int tests = 0;
    int fails = 0;

    cache_arbiter #(.ADDR_W(19), .DATA_W(16), .TIMEOUT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_cmd    (req_cmd),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .gnt        (gnt),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .c1_cmd_o   (c1_cmd_o),
        .c1_addr_o  (c1_addr_o),
        .c1_data_o  (c1_data_o),
        .c1_cmd_i   (c1_cmd_i),
        .c1_data_i  (c1_data_i)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic v, input logic [2:0] cmd, input logic [18:0] addr, input logic [31:0] wd);
        req_valid[p]         = v;
        req_cmd[3*p +: 3]    = cmd;
        req_addr[19*p +: 19] = addr;
        req_wdata[32*p +: 32] = wd;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req_valid = '0; req_cmd = '0; req_addr = '0; req_wdata = '0;
        c1_cmd_i = '0; c1_data_i = '0;
        tick; tick;
        tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
        tests++; if (resp_valid !== 2'b00) begin fails++; $display("FAIL reset_resp_valid: got %b expected 00", resp_valid); end
        tests++; if ({c1_cmd_o, c1_addr_o, c1_data_o} !== 38'h0) begin fails++; $display("FAIL reset_c1: got %h/%h/%h expected 0", c1_cmd_o, c1_addr_o, c1_data_o); end
        tests++; if ({resp_rdata, resp_err} !== 33'h0) begin fails++; $display("FAIL reset_resp: got %h/%b expected 0", resp_rdata, resp_err); end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_back_to_back;
        int grants[$];
        int exp_g[4] = '{0, 1, 0, 1};
        logic [1:0] prev_gnt = 2'b00;
        int cyc = 0;
        set_req(0, 1'b1, 3'd2, 19'h00200, 32'h0);
        set_req(1, 1'b1, 3'd1, 19'h00300, 32'h0);
        c1_cmd_i = 3'd7; c1_data_i = 16'h7788;
        while (grants.size() < 4 && cyc < 80) begin
            tick; cyc++;
            req_valid = 2'b11 & ~resp_valid;
            if (gnt != 2'b00 && prev_gnt == 2'b00) grants.push_back(int'(gnt[1]));
            if (resp_valid == 2'b01) begin
                tests++; if (resp_rdata !== 32'h00007788) begin fails++; $display("FAIL rr_read16_data: got %h expected 00007788", resp_rdata); end
            end
            if (resp_valid == 2'b10) begin
                tests++; if (resp_rdata !== 32'h00000088) begin fails++; $display("FAIL rr_read8_data: got %h expected 00000088", resp_rdata); end
            end
            prev_gnt = gnt;
        end
        tests++; if (grants.size() != 4) begin fails++; $display("FAIL rr_grant_count: got %0d expected 4", grants.size()); end
        for (int i = 0; i < grants.size(); i++) begin
            tests++; if (grants[i] != exp_g[i]) begin fails++; $display("FAIL rr_order[%0d]: got port %0d expected port %0d", i, grants[i], exp_g[i]); end
        end
        req_valid = gnt;
        while (gnt != 2'b00 && cyc < 100) begin
            tick; cyc++;
            req_valid = resp_valid != 2'b00 ? 2'b00 : gnt;
        end
        req_valid = '0; c1_cmd_i = '0;
        tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL rr_drain: got gnt %b expected 00", gnt); end
        tick;
    endtask

    task automatic test_read8;
        set_req(0, 1'b1, 3'd1, 19'h01234, 32'h0);
        tick;
        tests++; if (gnt !== 2'b01) begin fails++; $display("FAIL read8_gnt: got %b expected 01", gnt); end
        tests++; if (c1_cmd_o !== 3'd1 || c1_addr_o !== 19'h01234) begin fails++; $display("FAIL read8_send: got cmd %0d addr %h expected 1 01234", c1_cmd_o, c1_addr_o); end
        tick;
        tests++; if (c1_cmd_o !== 3'd0 || c1_addr_o !== 19'h0) begin fails++; $display("FAIL read8_wait_c1: got cmd %0d addr %h expected 0 0", c1_cmd_o, c1_addr_o); end
        tick;
        c1_cmd_i = 3'd7; c1_data_i = 16'h00AB;
        tests++; if (resp_valid !== 2'b00) begin fails++; $display("FAIL read8_early_resp: got %b expected 00", resp_valid); end
        tick;
        c1_cmd_i = 3'd0; c1_data_i = 16'h0;
        tests++; if (resp_valid !== 2'b01 || resp_rdata !== 32'h000000AB || resp_err !== 1'b0) begin fails++; $display("FAIL read8_resp: got %b %h %b expected 01 000000ab 0", resp_valid, resp_rdata, resp_err); end
        req_valid = '0;
        tick;
        tests++; if (resp_valid !== 2'b00 || gnt !== 2'b00) begin fails++; $display("FAIL read8_after: got resp %b gnt %b expected 00 00", resp_valid, gnt); end
    endtask

    task automatic test_write32;
        set_req(1, 1'b1, 3'd7, 19'h40010, 32'hDEADBEEF);
        tick;
        tests++; if (gnt !== 2'b10 || c1_cmd_o !== 3'd7 || c1_data_o !== 16'hBEEF || c1_addr_o !== 19'h40010) begin fails++; $display("FAIL wr32_lo: got gnt %b cmd %0d data %h addr %h expected 10 7 beef 40010", gnt, c1_cmd_o, c1_data_o, c1_addr_o); end
        tick;
        tests++; if (c1_cmd_o !== 3'd0 || c1_data_o !== 16'hDEAD || c1_addr_o !== 19'h40010) begin fails++; $display("FAIL wr32_hi: got cmd %0d data %h addr %h expected 0 dead 40010", c1_cmd_o, c1_data_o, c1_addr_o); end
        tick;
        tests++; if (c1_data_o !== 16'h0 || c1_addr_o !== 19'h0) begin fails++; $display("FAIL wr32_wait_c1: got data %h addr %h expected 0 0", c1_data_o, c1_addr_o); end
        c1_cmd_i = 3'd7; c1_data_i = 16'hFFFF;
        tick;
        c1_cmd_i = 3'd0;
        tests++; if (resp_valid !== 2'b10 || resp_rdata !== 32'h0) begin fails++; $display("FAIL wr32_resp: got %b %h expected 10 00000000", resp_valid, resp_rdata); end
        req_valid = '0;
        tick;
    endtask

    task automatic test_read32;
        set_req(0, 1'b1, 3'd3, 19'h00100, 32'h0);
        tick;
        tick;
        c1_cmd_i = 3'd7; c1_data_i = 16'h5678;
        tick;
        c1_cmd_i = 3'd0; c1_data_i = 16'h1234;
        tests++; if (resp_valid !== 2'b00) begin fails++; $display("FAIL rd32_recv_hi: got %b expected 00", resp_valid); end
        tick;
        c1_data_i = 16'h0;
        tests++; if (resp_valid !== 2'b01 || resp_rdata !== 32'h12345678) begin fails++; $display("FAIL rd32_resp: got %b %h expected 01 12345678", resp_valid, resp_rdata); end
        req_valid = '0;
        tick;
    endtask

    task automatic test_nop_ignored;
        logic p0_seen = 1'b0;
        logic [1:0] first_gnt = 2'b00;
        logic [2:0] sent = 3'd0;
        logic [1:0] rv = 2'b00;
        logic [31:0] rd = 32'hFFFFFFFF;
        int late_gnt = 0;
        set_req(0, 1'b1, 3'd0, 19'h00AAA, 32'h0);
        set_req(1, 1'b1, 3'd4, 19'h05550, 32'h0);
        c1_cmd_i = 3'd7; c1_data_i = 16'h1111;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (gnt[0]) p0_seen = 1'b1;
            if (first_gnt == 2'b00) first_gnt = gnt;
            if (c1_cmd_o != 3'd0) sent = c1_cmd_o;
            if (resp_valid != 2'b00) begin rv = resp_valid; rd = resp_rdata; req_valid[1] = 1'b0; end
        end
        for (int i = 0; i < 6; i++) begin
            tick;
            if (gnt != 2'b00) late_gnt++;
        end
        tests++; if (p0_seen !== 1'b0) begin fails++; $display("FAIL nop_p0_granted: got %b expected 0", p0_seen); end
        tests++; if (first_gnt !== 2'b10 || sent !== 3'd4) begin fails++; $display("FAIL nop_inv_grant: got gnt %b cmd %0d expected 10 4", first_gnt, sent); end
        tests++; if (rv !== 2'b10 || rd !== 32'h0) begin fails++; $display("FAIL nop_inv_resp: got %b %h expected 10 00000000", rv, rd); end
        tests++; if (late_gnt != 0) begin fails++; $display("FAIL nop_idle: got %0d grant cycles expected 0", late_gnt); end
        req_valid = '0; c1_cmd_i = '0; c1_data_i = '0;
        tick;
    endtask

`ifdef CACHE_ARBITER_TIMEOUT_EN
    task automatic test_timeout;
        int k = 0;
        int late = 0;
        set_req(1, 1'b1, 3'd1, 19'h00777, 32'h0);
        tick;
        while (resp_valid == 2'b00 && k < 20) begin tick; k++; end
        tests++; if (k != 5) begin fails++; $display("FAIL to_latency: got %0d cycles after SEND expected 5", k); end
        tests++; if (resp_valid !== 2'b10 || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin fails++; $display("FAIL to_resp: got %b err %b %h expected 10 1 00000000", resp_valid, resp_err, resp_rdata); end
        req_valid = '0;
        c1_cmd_i = 3'd7; c1_data_i = 16'h00CC;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (resp_valid != 2'b00 || gnt != 2'b00 || resp_err) late++;
        end
        tests++; if (late != 0) begin fails++; $display("FAIL to_late_resp: got %0d active cycles expected 0", late); end
        c1_cmd_i = '0; c1_data_i = '0;
    endtask
`endif

    task automatic test_reset_mid;
        int late = 0;
        set_req(0, 1'b1, 3'd2, 19'h03333, 32'h0);
        tick; tick; tick;
        tests++; if (gnt !== 2'b01) begin fails++; $display("FAIL rstmid_gnt_before: got %b expected 01", gnt); end
        rst_n = 1'b0;
        tick;
        tests++; if ({gnt, resp_valid, resp_err, resp_rdata, c1_cmd_o, c1_addr_o, c1_data_o} !== 75'h0) begin fails++; $display("FAIL rstmid_outputs: got gnt %b rv %b err %b rd %h c1 %h/%h/%h expected all 0", gnt, resp_valid, resp_err, resp_rdata, c1_cmd_o, c1_addr_o, c1_data_o); end
        req_valid = '0;
        c1_cmd_i = 3'd7; c1_data_i = 16'h4242;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (resp_valid != 2'b00 || gnt != 2'b00) late++;
        end
        tests++; if (late != 0) begin fails++; $display("FAIL rstmid_no_resp: got %0d active cycles expected 0", late); end
        c1_cmd_i = '0; c1_data_i = '0;
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_read8;
        test_write32;
        test_read32;
        test_nop_ignored;
`ifdef CACHE_ARBITER_TIMEOUT_EN
        test_timeout;
`endif
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
